// File: rtl/pc_fetch.sv
// Two-state (FETCH/EXEC) instruction fetch unit with next-PC selection.
// Handles branches, jumps, register jumps and exceptions, and reports the excepting PC in epc.
module pc_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  npc_op,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    input  logic        stall,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        nop,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        exc_flag
);

    typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_JR     = 3'b011;
    localparam logic [2:0] OP_EXCEPT = 3'b100;

    state_t      state, state_next;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        take_exc;
    logic        update;

    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};
    assign im_addr    = pc;
    assign nop        = !instr_valid;

    // Misaligned JR targets fall through to the exception path.
    always_comb begin
        take_exc = 1'b0;
        next_pc  = pc_plus4;
        case (npc_op)
            OP_BRANCH: next_pc = pc_plus4 + branch_off;
            OP_JUMP:   next_pc = {pc_plus4[31:28], imm26, 2'b00};
            OP_JR: begin
                if (rs_data[1:0] == 2'b00) next_pc = rs_data;
                else                       take_exc = 1'b1;
            end
            OP_EXCEPT: take_exc = 1'b1;
            default:   next_pc = pc_plus4;
        endcase
        if (take_exc) next_pc = EXC_VECTOR;
    end

    always_comb begin
        state_next  = state;
        im_req      = 1'b0;
        instr_valid = 1'b0;
        exc_flag    = 1'b0;
        update      = 1'b0;
        case (state)
            FETCH: begin
                im_req = 1'b1;
                if (im_ack) state_next = EXEC;
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    state_next = FETCH;
                    update     = 1'b1;
                    exc_flag   = take_exc;
                end
            end
            default: state_next = FETCH;
        endcase
        // Reset masks all outputs in the same cycle, so a late ack cannot leak through.
        if (rst) begin
            state_next  = FETCH;
            im_req      = 1'b0;
            instr_valid = 1'b0;
            exc_flag    = 1'b0;
            update      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            instr <= 32'd0;
            epc   <= 32'd0;
        end else begin
            state <= state_next;
            if (state == FETCH && im_ack) instr <= im_rdata;
            if (update) begin
                pc <= next_pc;
                if (take_exc) epc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed plus randomized bench for pc_fetch against a transaction-level PC model.
module tb_pc_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_V  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  npc_op;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_data;
    logic        stall;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        nop;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        exc_flag;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: "busy" means an instruction is held for execution.
    bit          m_busy;
    logic [31:0] m_pc, m_instr, m_epc;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_V)) dut (
        .clk(clk), .rst(rst), .npc_op(npc_op), .imm16(imm16), .imm26(imm26),
        .rs_data(rs_data), .stall(stall), .im_req(im_req), .im_addr(im_addr),
        .im_ack(im_ack), .im_rdata(im_rdata), .instr(instr), .instr_valid(instr_valid),
        .nop(nop), .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .exc_flag(exc_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_exc(input logic [2:0] op, input logic [31:0] rs);
        return (op == 3'd4) || (op == 3'd3 && (rs % 4) != 0);
    endfunction

    function automatic logic [31:0] target(input logic [31:0] cur, input logic [2:0] op,
                                           input logic [15:0] i16, input logic [25:0] i26,
                                           input logic [31:0] rs);
        longint seq, off;
        seq = (longint'(cur) + 4) % 64'h1_0000_0000;
        off = longint'($signed(i16)) * 4;
        if (is_exc(op, rs)) return EXC_V;
        case (op)
            3'd1:    return 32'(seq + off);
            3'd2:    return 32'((seq / 32'h1000_0000) * 32'h1000_0000 + longint'(i26) * 4);
            3'd3:    return rs;
            default: return 32'(seq);
        endcase
    endfunction

    // One clock: check combinational outputs before the edge, advance the model, check state after.
    task automatic tick();
        bit exp_req, exp_vld, exp_exc;
        #1;
        exp_req = !rst && !m_busy;
        exp_vld = !rst && m_busy;
        exp_exc = exp_vld && !stall && is_exc(npc_op, rs_data);
        chk("im_req", 32'(im_req), 32'(exp_req));
        if (exp_req) chk("im_addr", im_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(exp_vld));
        chk("nop", 32'(nop), 32'(!exp_vld));
        chk("exc_flag", 32'(exc_flag), 32'(exp_exc));
        if (rst) begin
            m_busy = 0; m_pc = RST_PC; m_instr = 0; m_epc = 0;
        end else if (!m_busy) begin
            if (im_ack) begin m_instr = im_rdata; m_busy = 1; end
        end else if (!stall) begin
            if (exp_exc) m_epc = m_pc;
            m_pc   = target(m_pc, npc_op, imm16, imm26, rs_data);
            m_busy = 0;
        end
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("instr", instr, m_instr);
        chk("epc", epc, m_epc);
    endtask

    // Fetch with zero wait states, then execute with the given next-PC controls.
    task automatic run_instr(input logic [2:0] op, input logic [15:0] i16,
                             input logic [25:0] i26, input logic [31:0] rs);
        im_ack = 1; im_rdata = $urandom; stall = 0;
        tick();
        im_ack = 0; npc_op = op; imm16 = i16; imm26 = i26; rs_data = rs;
        tick();
    endtask

    initial begin
        rst = 1; npc_op = 0; imm16 = 0; imm26 = 0; rs_data = 0; stall = 0;
        im_ack = 0; im_rdata = 0;
        m_busy = 0; m_pc = RST_PC; m_instr = 0; m_epc = 0;
        @(posedge clk); #1;
        tick();
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'd0);

        // First instruction after reset, zero wait states.
        rst = 0; im_ack = 1; im_rdata = 32'h2008_0005;
        tick();
        chk("first_instr", instr, 32'h2008_0005);
        chk("first_valid", 32'(instr_valid), 32'd1);
        im_ack = 0; npc_op = 3'd0;
        tick();
        chk("second_addr", im_addr, 32'h0000_3004);

        run_instr(3'd0, 16'h0, 26'h0, 32'h0);
        run_instr(3'd7, 16'h0, 26'h0, 32'h0);
        run_instr(3'd5, 16'h0, 26'h0, 32'h0);
        chk("pc_3010", pc, 32'h0000_3010);
        run_instr(3'd1, 16'hFFFC, 26'h0, 32'h0);
        chk("branch_back", im_addr, 32'h0000_3004);

        run_instr(3'd3, 16'h0, 26'h0, 32'hA000_0000);
        chk("jr_aligned", pc, 32'hA000_0000);
        run_instr(3'd2, 16'h0, 26'h0000C00, 32'h0);
        chk("jump", im_addr, 32'hA000_3000);
        run_instr(3'd3, 16'h0, 26'h0, 32'h0000_3022);
        chk("jr_misaligned", im_addr, EXC_V);
        chk("epc_jr", epc, 32'hA000_3000);

        // Stall held for three EXEC cycles, then released.
        im_ack = 1; im_rdata = 32'h1234_5678;
        tick();
        im_ack = 0; stall = 1; npc_op = 3'd0;
        repeat (3) tick();
        chk("stall_pc", pc, EXC_V);
        stall = 0;
        tick();
        chk("stall_release", pc, EXC_V + 32'd4);
        tick();
        chk("one_update", pc, EXC_V + 32'd4);

        // Slow memory, reset arrives mid-fetch along with a late ack.
        im_ack = 0;
        tick(); tick();
        rst = 1; im_ack = 1; im_rdata = 32'hDEAD_BEEF;
        tick();
        chk("midfetch_rst_pc", pc, RST_PC);
        rst = 0; im_ack = 0;
        #1;
        chk("fresh_req", 32'(im_req), 32'd1);
        chk("fresh_addr", im_addr, RST_PC);
        chk("late_ack_dropped", instr, 32'd0);
        tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            im_ack   = $urandom_range(0, 1);
            im_rdata = $urandom;
            stall    = ($urandom_range(0, 9) < 3);
            npc_op   = 3'($urandom_range(0, 7));
            imm16    = 16'($urandom);
            imm26    = 26'($urandom);
            rs_data  = $urandom;
            if ($urandom_range(0, 9) < 7) rs_data[1:0] = 2'b00;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000: first fetch address after reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_4180: target PC on exception.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset, sampled on rising clk.
REQ-005 SHALL have port npc_op, input, 3: next-PC select from controller; 000 PLUS4, 001 BRANCH, 010 JUMP, 011 JR, 100 EXCEPT.
REQ-006 SHALL have port imm16, input, 16: branch offset field of the current instruction.
REQ-007 SHALL have port imm26, input, 26: jump index field of the current instruction.
REQ-008 SHALL have port rs_data, input, 32: JR target register value.
REQ-009 SHALL have port stall, input, 1: holds the current instruction in EXEC.
REQ-010 SHALL have port im_req, output, 1: instruction memory request.
REQ-011 SHALL have port im_addr, output, 32: instruction memory address.
REQ-012 SHALL have port im_ack, input, 1: memory response valid.
REQ-013 SHALL have port im_rdata, input, 32: memory read data, valid when im_ack=1.
REQ-014 SHALL have port instr, output, 32: current instruction word.
REQ-015 SHALL have port instr_valid, output, 1: instr is live this cycle.
REQ-016 SHALL have port nop, output, 1: equal to !instr_valid; drives the controller nop input.
REQ-017 SHALL have port pc, output, 32: address of the current instruction.
REQ-018 SHALL have port pc_plus4, output, 32: pc+4, used as link value by jal.
REQ-019 SHALL have port epc, output, 32: PC of the last excepting instruction.
REQ-020 SHALL have port exc_flag, output, 1: one-cycle pulse when an exception is taken.

Function
REQ-021 SHALL implement FSM states FETCH and EXEC.
REQ-022 FETCH SHALL drive im_req=1 and im_addr=pc, holding both stable until im_ack=1.
REQ-023 On im_ack=1 in FETCH, the block SHALL latch im_rdata into instr and enter EXEC on the next cycle.
REQ-024 im_ack SHALL be ignored in EXEC.
REQ-025 In EXEC, instr_valid SHALL be 1 and im_req SHALL be 0.
REQ-026 In EXEC with stall=1, instr, pc and state SHALL hold.
REQ-027 In EXEC with stall=0, pc SHALL load next_pc and the FSM SHALL return to FETCH.
REQ-028 PLUS4: next_pc = pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-029 BRANCH: next_pc = pc+4 + (sign-extended imm16 << 2), modulo 2^32.
REQ-030 JUMP: next_pc = {pc_plus4[31:28], imm26, 2'b00}.
REQ-031 JR: next_pc = rs_data when rs_data[1:0]==0; otherwise the instruction SHALL be treated as EXCEPT.
REQ-032 EXCEPT: next_pc = EXC_VECTOR; epc <= pc; exc_flag=1 for exactly the update cycle.
REQ-033 npc_op codes 101-111 SHALL behave as PLUS4.
REQ-034 npc_op and the operand inputs SHALL be ignored whenever instr_valid=0.
REQ-035 Minimum instruction period SHALL be 2 cycles (ack in cycle N, EXEC in N+1, next req in N+2).

Reset
REQ-036 While rst=1: state=FETCH, pc=RESET_PC, instr=0, epc=0, exc_flag=0, instr_valid=0, nop=1, im_req=0.
REQ-037 im_req SHALL first assert in the cycle after rst deasserts, with im_addr=RESET_PC.
REQ-038 Reset mid-fetch or mid-EXEC SHALL abandon the operation.
REQ-039 An im_ack in a cycle where rst=1 SHALL be discarded.

Verification
REQ-040 Reset release, ack with 0 wait cycles, rdata=32'h2008_0005, npc_op=000 -> instr_valid one cycle; second im_addr=32'h0000_3004.
REQ-041 pc=32'h0000_3010, npc_op=001, imm16=16'hFFFC -> next im_addr=32'h0000_3004.
REQ-042 pc=32'hA000_0000, npc_op=010, imm26=26'h0000C00 -> next im_addr=32'hA000_3000; npc_op=011, rs_data=32'h0000_3022 -> im_addr=EXC_VECTOR, epc=pc, exc_flag pulses once.
REQ-043 stall=1 for 3 EXEC cycles -> instr and pc constant, im_req=0; stall falls -> exactly one PC update.
REQ-044 im_ack held 0 for 5 cycles -> im_req and im_addr stable; rst asserted on cycle 3 -> pc=RESET_PC, the late ack is ignored, and a fresh request starts at RESET_PC.
